// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared types and constants for the writeback arbiter slice.
//   NREG / AW / DW : register count, register address width, data width
//   wb_req_t       : one register-file write request {wa, wd}
//   wa_onehot()    : register address to one-hot register mask
// -----------------------------------------------------------------------------
package wb_pkg;

    localparam int NREG = 16;
    localparam int AW   = 4;
    localparam int DW   = 32;

    typedef struct packed {
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
    } wb_req_t;

    // Decode a register address into its bit of a pending/hazard mask.
    function automatic logic [NREG-1:0] wa_onehot(input logic [AW-1:0] wa);
        logic [NREG-1:0] v_mask;
        v_mask = {{(NREG-1){1'b0}}, 1'b1} << wa;
        return v_mask;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// wb_arbiter_if
// Bundle of the writeback arbiter's bus signals.
//   master : upstream/regfile side (drives ALU and load requests)
//   slave  : the arbiter (drives ld_ready, we3/wa3/wd3, pend, count, waw_err)
// -----------------------------------------------------------------------------
interface wb_arbiter_if #(
    parameter int DEPTH = 4
);
    import wb_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic            alu_valid;
    logic [AW-1:0]   alu_wa;
    logic [DW-1:0]   alu_wd;
    logic            ld_valid;
    logic            ld_ready;
    logic [AW-1:0]   ld_wa;
    logic [DW-1:0]   ld_wd;
    logic            we3;
    logic [AW-1:0]   wa3;
    logic [DW-1:0]   wd3;
    logic [NREG-1:0] pend;
    logic [CW-1:0]   count;
    logic            waw_err;

    modport master (
        output alu_valid, alu_wa, alu_wd, ld_valid, ld_wa, ld_wd,
        input  ld_ready, we3, wa3, wd3, pend, count, waw_err
    );

    modport slave (
        input  alu_valid, alu_wa, alu_wd, ld_valid, ld_wa, ld_wd,
        output ld_ready, we3, wa3, wd3, pend, count, waw_err
    );

endinterface

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Synchronous FIFO of wb_req_t holding accepted-but-not-yet-written loads.
//   clk, reset : clock and synchronous active-low reset
//   i_push     : write i_data at the tail
//   i_pop      : drop the head entry
//   o_head     : current head entry
//   o_count    : occupancy, 0..DEPTH
//   o_ent_vld  : per-slot valid bits
//   o_ent_wa   : per-slot destination register (meaningful where valid)
// -----------------------------------------------------------------------------
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_push,
    input  wb_req_t                     i_data,
    input  logic                        i_pop,
    output wb_req_t                     o_head,
    output logic [$clog2(DEPTH):0]      o_count,
    output logic [DEPTH-1:0]            o_ent_vld,
    output logic [DEPTH-1:0][AW-1:0]    o_ent_wa
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_req_t          r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic [DEPTH-1:0] r_vld;
    logic [DEPTH-1:0] w_vld_nxt;

    // Slot-valid update: pop clears the head slot, push sets the tail slot.
    always_comb begin
        w_vld_nxt = r_vld;
        if (i_pop) begin
            w_vld_nxt[r_rd_ptr] = 1'b0;
        end else begin
            w_vld_nxt = w_vld_nxt;
        end
        if (i_push) begin
            w_vld_nxt[r_wr_ptr] = 1'b1;
        end else begin
            w_vld_nxt = w_vld_nxt;
        end
    end

    // Pointer, occupancy and slot-valid registers; pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_vld    <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            r_vld <= w_vld_nxt;
        end
    end

    // Payload storage; slot contents only matter where r_vld is set.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end

    // Expose per-slot destination registers for the pending mask.
    always_comb begin
        o_ent_wa = '0;
        for (int i = 0; i < DEPTH; i++) begin
            o_ent_wa[i] = r_mem[i].wa;
        end
    end

    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;
    assign o_ent_vld = r_vld;

    wb_fifo_chk #(.DEPTH(DEPTH)) u_chk (
        .clk   (clk),
        .reset (reset),
        .push  (i_push),
        .pop   (i_pop),
        .count (r_count)
    );

endmodule

// File: rtl/wb_fifo_chk.sv
// -----------------------------------------------------------------------------
// wb_fifo_chk
// Protocol checker for wb_fifo: no push when full, no pop when empty.
//   clk, reset : clock and synchronous active-low reset
//   push, pop  : FIFO strobes
//   count      : FIFO occupancy
// -----------------------------------------------------------------------------
module wb_fifo_chk #(
    parameter int DEPTH = 4
) (
    input logic                     clk,
    input logic                     reset,
    input logic                     push,
    input logic                     pop,
    input logic [$clog2(DEPTH):0]   count
);
    localparam int CW = $clog2(DEPTH) + 1;

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(push && !pop && (count == CW'(DEPTH))));

    a_no_push_full: assert property (@(posedge clk) disable iff (!reset)
        !(push && (count == CW'(DEPTH))));

    a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
        !(pop && (count == CW'(0))));

endmodule

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Merges ALU results and load results onto the single register-file write
// port. Priority: ALU, then FIFO head, then bypass of an incoming load when
// the FIFO is empty. Exports a pending-register mask for hazard stalls and a
// sticky WAW error flag.
//   clk   : clock, all state on rising edge
//   reset : synchronous active-low reset
//   bus   : wb_arbiter_if.slave (ALU/load requests in; ld_ready, we3/wa3/wd3,
//           pend, count, waw_err out)
// -----------------------------------------------------------------------------
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    wb_arbiter_if.slave     bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                     w_empty;
    logic                     w_full;
    logic                     w_ld_ready;
    logic                     w_ld_acc;
    logic                     w_bypass;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_sel_vld;
    logic                     w_sel_ld;
    wb_req_t                  w_sel;
    wb_req_t                  w_head;
    wb_req_t                  w_ld_req;
    logic [CW-1:0]            w_count;
    logic [DEPTH-1:0]         w_ent_vld;
    logic [DEPTH-1:0][AW-1:0] w_ent_wa;
    logic [NREG-1:0]          w_pend;

    logic                     r_we3;
    logic [AW-1:0]            r_wa3;
    logic [DW-1:0]            r_wd3;
    logic                     r_out_ld;
    logic                     r_waw_err;

    assign w_empty    = (w_count == CW'(0));
    assign w_full     = (w_count == CW'(DEPTH));
    // No credit for a same-cycle pop: readiness is purely from stored count.
    assign w_ld_ready = reset & ~w_full;
    assign w_ld_acc   = bus.ld_valid & w_ld_ready;
    assign w_ld_req   = {bus.ld_wa, bus.ld_wd};

    // Write-source selection and FIFO push/pop strobes.
    always_comb begin
        w_sel     = '0;
        w_sel_vld = 1'b0;
        w_sel_ld  = 1'b0;
        w_pop     = 1'b0;
        w_bypass  = 1'b0;
        if (bus.alu_valid) begin
            w_sel_vld = 1'b1;
            w_sel     = {bus.alu_wa, bus.alu_wd};
        end else if (!w_empty) begin
            w_sel_vld = 1'b1;
            w_sel_ld  = 1'b1;
            w_sel     = w_head;
            w_pop     = 1'b1;
        end else if (w_ld_acc) begin
            w_sel_vld = 1'b1;
            w_sel_ld  = 1'b1;
            w_sel     = w_ld_req;
            w_bypass  = 1'b1;
        end else begin
            w_sel_vld = 1'b0;
        end
        w_push = w_ld_acc & ~w_bypass;
    end

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push    (w_push),
        .i_data    (w_ld_req),
        .i_pop     (w_pop),
        .o_head    (w_head),
        .o_count   (w_count),
        .o_ent_vld (w_ent_vld),
        .o_ent_wa  (w_ent_wa)
    );

    // Output write register; wa3/wd3 hold their value on idle cycles.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_we3    <= 1'b0;
            r_wa3    <= '0;
            r_wd3    <= '0;
            r_out_ld <= 1'b0;
        end else begin
            r_we3    <= w_sel_vld;
            r_out_ld <= w_sel_ld;
            if (w_sel_vld) begin
                r_wa3 <= w_sel.wa;
                r_wd3 <= w_sel.wd;
            end
        end
    end

    // Pending mask: queued loads plus a load sitting in the output register.
    always_comb begin
        w_pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_ent_vld[i]) begin
                w_pend = w_pend | wa_onehot(w_ent_wa[i]);
            end else begin
                w_pend = w_pend;
            end
        end
        if (r_we3 && r_out_ld) begin
            w_pend = w_pend | wa_onehot(r_wa3);
        end else begin
            w_pend = w_pend;
        end
    end

    // Sticky WAW flag: an ALU write hit a register still owed by a load.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_waw_err <= 1'b0;
        end else if (bus.alu_valid && w_pend[bus.alu_wa]) begin
            r_waw_err <= 1'b1;
        end
    end

    assign bus.ld_ready = w_ld_ready;
    assign bus.we3      = r_we3;
    assign bus.wa3      = r_wa3;
    assign bus.wd3      = r_wd3;
    assign bus.pend     = w_pend;
    assign bus.count    = w_count;
    assign bus.waw_err  = r_waw_err;

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
// Self-checking bench for wb_arbiter: a write-order scoreboard fed from a
// small behavioural model at drive time, a vector table for the fill/drain
// sequence, and hand-written reset/bypass/ordering/WAW sequences.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;
    import wb_pkg::*;

    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   ntests = 0;
    int   nfail  = 0;

    wb_req_t sbq[$];
    wb_req_t mq[$];
    wb_req_t mon_exp;

    typedef struct {
        logic        av;
        logic [3:0]  awa;
        logic        lv;
        logic [3:0]  lwa;
        logic        rdy;
        logic [2:0]  cnt;
        logic [15:0] pend;
    } vec_t;

    vec_t vt [13];

    wb_arbiter_if #(.DEPTH(DEPTH)) bus_if ();

    wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Scoreboard: every register-file write must be the next expected one.
    always @(negedge clk) begin
        if (bus_if.we3 === 1'b1) begin
            ntests++;
            if (sbq.size() == 0) begin
                nfail++;
                $display("FAIL wr_unexpected: got wa3=%0d wd3=%h, required no write",
                         bus_if.wa3, bus_if.wd3);
            end else begin
                mon_exp = sbq.pop_front();
                if (bus_if.wa3 !== mon_exp.wa || bus_if.wd3 !== mon_exp.wd) begin
                    nfail++;
                    $display("FAIL wr_order: got wa3=%0d wd3=%h, required wa3=%0d wd3=%h",
                             bus_if.wa3, bus_if.wd3, mon_exp.wa, mon_exp.wd);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of requests and predict the resulting write order.
    task automatic drive(input logic av, input logic [3:0] awa, input logic [31:0] awd,
                         input logic lv, input logic [3:0] lwa, input logic [31:0] lwd);
        logic acc;
        bus_if.alu_valid = av;
        bus_if.alu_wa    = awa;
        bus_if.alu_wd    = awd;
        bus_if.ld_valid  = lv;
        bus_if.ld_wa     = lwa;
        bus_if.ld_wd     = lwd;
        acc = lv && reset && (mq.size() < DEPTH);
        if (av) begin
            sbq.push_back(wb_req_t'({awa, awd}));
        end else if (mq.size() != 0) begin
            sbq.push_back(mq.pop_front());
        end else if (acc) begin
            sbq.push_back(wb_req_t'({lwa, lwd}));
            acc = 1'b0;
        end
        if (acc) mq.push_back(wb_req_t'({lwa, lwd}));
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Fill/drain table: 6 ALU cycles with loads r1..r5, then drain.
        vt[0]  = '{1'b1, 4'd10, 1'b1, 4'd1, 1'b1, 3'd0, 16'h0000};
        vt[1]  = '{1'b1, 4'd11, 1'b1, 4'd2, 1'b1, 3'd1, 16'h0002};
        vt[2]  = '{1'b1, 4'd12, 1'b1, 4'd3, 1'b1, 3'd2, 16'h0006};
        vt[3]  = '{1'b1, 4'd13, 1'b1, 4'd4, 1'b1, 3'd3, 16'h000E};
        vt[4]  = '{1'b1, 4'd14, 1'b1, 4'd5, 1'b0, 3'd4, 16'h001E};
        vt[5]  = '{1'b1, 4'd15, 1'b1, 4'd5, 1'b0, 3'd4, 16'h001E};
        vt[6]  = '{1'b0, 4'd0,  1'b1, 4'd5, 1'b0, 3'd4, 16'h001E};
        vt[7]  = '{1'b0, 4'd0,  1'b1, 4'd5, 1'b1, 3'd3, 16'h001E};
        vt[8]  = '{1'b0, 4'd0,  1'b0, 4'd0, 1'b1, 3'd3, 16'h003C};
        vt[9]  = '{1'b0, 4'd0,  1'b0, 4'd0, 1'b1, 3'd2, 16'h0038};
        vt[10] = '{1'b0, 4'd0,  1'b0, 4'd0, 1'b1, 3'd1, 16'h0030};
        vt[11] = '{1'b0, 4'd0,  1'b0, 4'd0, 1'b1, 3'd0, 16'h0020};
        vt[12] = '{1'b0, 4'd0,  1'b0, 4'd0, 1'b1, 3'd0, 16'h0000};

        // Reset state, with a load offered to check ld_ready is held low.
        bus_if.alu_valid = 1'b0;
        bus_if.alu_wa    = 4'd0;
        bus_if.alu_wd    = 32'd0;
        bus_if.ld_valid  = 1'b1;
        bus_if.ld_wa     = 4'd9;
        bus_if.ld_wd     = 32'h5555_5555;
        repeat (2) next_cycle();
        @(negedge clk);
        chk("rst_ld_ready", 32'(bus_if.ld_ready), 32'd0);
        chk("rst_we3",      32'(bus_if.we3),      32'd0);
        chk("rst_wa3",      32'(bus_if.wa3),      32'd0);
        chk("rst_wd3",      bus_if.wd3,           32'd0);
        chk("rst_count",    32'(bus_if.count),    32'd0);
        chk("rst_pend",     32'(bus_if.pend),     32'd0);
        chk("rst_waw",      32'(bus_if.waw_err),  32'd0);
        next_cycle();
        reset = 1'b1;
        idle();
        @(negedge clk);
        chk("idle_ld_ready", 32'(bus_if.ld_ready), 32'd1);
        next_cycle();

        // Single ALU write, then idle with wa3/wd3 held.
        drive(1'b1, 4'd3, 32'hDEAD_BEEF, 1'b0, 4'd0, 32'd0);
        next_cycle();
        chk("alu_we3", 32'(bus_if.we3), 32'd1);
        chk("alu_wa3", 32'(bus_if.wa3), 32'd3);
        chk("alu_wd3", bus_if.wd3,      32'hDEAD_BEEF);
        idle();
        next_cycle();
        chk("alu_we3_off",  32'(bus_if.we3), 32'd0);
        chk("alu_wa3_hold", 32'(bus_if.wa3), 32'd3);
        chk("alu_wd3_hold", bus_if.wd3,      32'hDEAD_BEEF);

        // Lone load on an empty FIFO is bypassed.
        drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd5, 32'h0000_1234);
        @(negedge clk);
        chk("byp_ready", 32'(bus_if.ld_ready), 32'd1);
        next_cycle();
        chk("byp_we3",   32'(bus_if.we3),   32'd1);
        chk("byp_wa3",   32'(bus_if.wa3),   32'd5);
        chk("byp_wd3",   bus_if.wd3,        32'h0000_1234);
        chk("byp_count", 32'(bus_if.count), 32'd0);
        chk("byp_pend",  32'(bus_if.pend),  32'h0020);
        idle();
        next_cycle();
        chk("byp_pend_clr", 32'(bus_if.pend), 32'd0);

        // Table-driven fill past full, back-pressure, and in-order drain.
        for (int i = 0; i < 13; i++) begin
            drive(vt[i].av, vt[i].awa, 32'hA000_0000 + 32'(i),
                  vt[i].lv, vt[i].lwa, 32'hB000_0000 + 32'(i));
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", i), 32'(bus_if.ld_ready), 32'(vt[i].rdy));
            chk($sformatf("tbl%0d_count", i), 32'(bus_if.count),    32'(vt[i].cnt));
            chk($sformatf("tbl%0d_pend",  i), 32'(bus_if.pend),     32'(vt[i].pend));
            next_cycle();
        end

        // Simultaneous ALU r7 and load r8: ALU first, r8 next cycle.
        drive(1'b1, 4'd7, 32'h0000_0077, 1'b1, 4'd8, 32'h0000_0088);
        next_cycle();
        chk("sim_wa3_a",  32'(bus_if.wa3),   32'd7);
        chk("sim_count",  32'(bus_if.count), 32'd1);
        chk("sim_pend_a", 32'(bus_if.pend),  32'h0100);
        idle();
        next_cycle();
        chk("sim_we3_b",  32'(bus_if.we3),  32'd1);
        chk("sim_wa3_b",  32'(bus_if.wa3),  32'd8);
        chk("sim_wd3_b",  bus_if.wd3,       32'h0000_0088);
        chk("sim_pend_b", 32'(bus_if.pend), 32'h0100);
        idle();
        next_cycle();
        chk("sim_pend_c", 32'(bus_if.pend), 32'd0);
        chk("sim_waw",    32'(bus_if.waw_err), 32'd0);

        // Reset with three queued loads discards them.
        drive(1'b1, 4'd10, 32'hC000_000A, 1'b1, 4'd1, 32'hD000_0001);
        next_cycle();
        drive(1'b1, 4'd11, 32'hC000_000B, 1'b1, 4'd2, 32'hD000_0002);
        next_cycle();
        drive(1'b1, 4'd12, 32'hC000_000C, 1'b1, 4'd3, 32'hD000_0003);
        next_cycle();
        reset = 1'b0;
        mq.delete();
        idle();
        @(negedge clk);
        chk("prerst_count", 32'(bus_if.count),    32'd3);
        chk("prerst_pend",  32'(bus_if.pend),     32'h000E);
        chk("inrst_ready",  32'(bus_if.ld_ready), 32'd0);
        next_cycle();
        chk("midrst_count", 32'(bus_if.count), 32'd0);
        chk("midrst_pend",  32'(bus_if.pend),  32'd0);
        chk("midrst_we3",   32'(bus_if.we3),   32'd0);
        reset = 1'b1;
        repeat (4) next_cycle();
        chk("postrst_we3",   32'(bus_if.we3),   32'd0);
        chk("postrst_count", 32'(bus_if.count), 32'd0);

        // WAW: ALU write to r2 while a load to r2 is queued.
        drive(1'b1, 4'd9, 32'h0000_0099, 1'b1, 4'd2, 32'h0000_0022);
        next_cycle();
        drive(1'b1, 4'd2, 32'h0000_00A2, 1'b0, 4'd0, 32'd0);
        @(negedge clk);
        chk("waw_pend",   32'(bus_if.pend),    32'h0004);
        chk("waw_before", 32'(bus_if.waw_err), 32'd0);
        next_cycle();
        chk("waw_set",   32'(bus_if.waw_err), 32'd1);
        chk("waw_alu_wa3", 32'(bus_if.wa3),   32'd2);
        chk("waw_alu_wd3", bus_if.wd3,        32'h0000_00A2);
        idle();
        next_cycle();
        chk("waw_ld_we3", 32'(bus_if.we3), 32'd1);
        chk("waw_ld_wd3", bus_if.wd3,      32'h0000_0022);
        repeat (3) next_cycle();
        chk("waw_sticky", 32'(bus_if.waw_err), 32'd1);
        reset = 1'b0;
        mq.delete();
        next_cycle();
        reset = 1'b1;
        chk("waw_cleared", 32'(bus_if.waw_err), 32'd0);

        repeat (2) next_cycle();
        chk("sb_drained", 32'(sbq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
